// File: rtl/button_pkg.sv
// Shared definitions for the push-button debouncer: per-button FSM state
// encoding and the board button bit positions.
package button_pkg;

  // Per-button filter state. The MSB matches the accepted level in both stable
  // states. Each WAIT state counts samples toward the opposite level.
  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    WAIT_HI   = 2'b01,
    STABLE_HI = 2'b11,
    WAIT_LO   = 2'b10
  } db_state_e;

  // Bit positions of the board buttons on the raw bus.
  localparam int BTN_U = 0;
  localparam int BTN_D = 1;
  localparam int BTN_L = 2;
  localparam int BTN_R = 3;
  localparam int BTN_C = 4;

endpackage

// File: rtl/debounce_bit.sv
// Single-button debouncer: 2-flop synchroniser, stability counter and
// registered level / press / release outputs.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// STABLE_LO | accepted level 0, counter idle at 0
// WAIT_HI   | sync input went 1, counting consecutive 1 samples
// STABLE_HI | accepted level 1, counter idle at 0
// WAIT_LO   | sync input went 0, counting consecutive 0 samples
module debounce_bit
  import button_pkg::*;
#(
  parameter int DB_CYCLES = 4,
  parameter int CW        = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic db_o,
  output logic press_o,
  output logic release_o
);

  // The last count value before acceptance. The counter never goes past it,
  // so CW = clog2(DB_CYCLES) bits are enough.
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic            sync1_q;
  logic            sync2_q;
  db_state_e       state_q;
  logic [CW-1:0]   cnt_q;
  logic            db_q;
  logic            press_q;
  logic            release_q;

  // Two-flop synchroniser for the asynchronous raw button level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Filter FSM with counter and registered outputs. A single opposite sample
  // aborts a wait, so there is no partial credit for a bouncing input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= STABLE_LO;
      cnt_q     <= '0;
      db_q      <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      case (state_q)
        STABLE_LO: begin
          if (sync2_q) begin
            state_q <= WAIT_HI;
            cnt_q   <= CW'(1);
          end else begin
            cnt_q   <= '0;
          end
        end
        WAIT_HI: begin
          if (!sync2_q) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= STABLE_HI;
            cnt_q   <= '0;
            db_q    <= 1'b1;
            press_q <= 1'b1;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
          end
        end
        STABLE_HI: begin
          if (!sync2_q) begin
            state_q <= WAIT_LO;
            cnt_q   <= CW'(1);
          end else begin
            cnt_q   <= '0;
          end
        end
        WAIT_LO: begin
          if (sync2_q) begin
            state_q   <= STABLE_HI;
            cnt_q     <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= STABLE_LO;
            cnt_q     <= '0;
            db_q      <= 1'b0;
            release_q <= 1'b1;
          end else begin
            cnt_q     <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= STABLE_LO;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign db_o      = db_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/button_debouncer.sv
// Debouncer for the raw push-button bus. Each button gets its own debounce_bit
// instance, and the instances share nothing.
module button_debouncer
  import button_pkg::*;
#(
  parameter int Nbtn      = 5,
  parameter int DB_CYCLES = 1000000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [Nbtn-1:0] btn,
  output logic [Nbtn-1:0] btn_db,
  output logic [Nbtn-1:0] btn_press,
  output logic [Nbtn-1:0] btn_release
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  for (genvar g = 0; g < Nbtn; g++) begin : g_btn
    debounce_bit #(
      .DB_CYCLES (DB_CYCLES),
      .CW        (CW)
    ) u_bit (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_i     (btn[g]),
      .db_o      (btn_db[g]),
      .press_o   (btn_press[g]),
      .release_o (btn_release[g])
    );
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DB_CYCLES=4 and Nbtn=5.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_button_debouncer;

  localparam int NB = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NB-1:0] btn;
  logic [NB-1:0] btn_db;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;

  int n_assert = 0;
  int n_fail   = 0;

  logic [9:0] bounce_pat;

  button_debouncer #(
    .Nbtn      (NB),
    .DB_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn         (btn),
    .btn_db      (btn_db),
    .btn_press   (btn_press),
    .btn_release (btn_release)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [NB-1:0] db,
                         input logic [NB-1:0] pr, input logic [NB-1:0] rl);
    chk({tag, ".db"}, btn_db, db);
    chk({tag, ".press"}, btn_press, pr);
    chk({tag, ".release"}, btn_release, rl);
  endtask

  initial begin
    // Reset held with every button pressed.
    rst_n = 1'b0;
    btn   = 5'b11111;
    repeat (4) step();
    chk_all("reset_hold", 5'b00000, 5'b00000, 5'b00000);

    // Release reset, with the buttons still held. The held buttons are reported as a fresh press after edge 6.
    rst_n = 1'b1;
    repeat (5) step();
    chk_all("held_edge5", 5'b00000, 5'b00000, 5'b00000);
    step();
    chk_all("held_edge6", 5'b11111, 5'b11111, 5'b00000);
    step();
    chk_all("held_edge7", 5'b11111, 5'b00000, 5'b00000);

    // Release all of the buttons. Release is reported 6 edges later.
    btn = 5'b00000;
    repeat (5) step();
    chk_all("relall_edge5", 5'b11111, 5'b00000, 5'b00000);
    step();
    chk_all("relall_edge6", 5'b00000, 5'b00000, 5'b11111);
    step();
    chk_all("relall_edge7", 5'b00000, 5'b00000, 5'b00000);
    repeat (3) step();

    // Clean press on btn[0], then release it.
    btn[0] = 1'b1;
    repeat (5) step();
    chk_all("press0_edge5", 5'b00000, 5'b00000, 5'b00000);
    step();
    chk_all("press0_edge6", 5'b00001, 5'b00001, 5'b00000);
    step();
    chk_all("press0_edge7", 5'b00001, 5'b00000, 5'b00000);
    repeat (4) step();
    chk_all("press0_hold", 5'b00001, 5'b00000, 5'b00000);
    btn[0] = 1'b0;
    repeat (5) step();
    chk_all("rel0_edge5", 5'b00001, 5'b00000, 5'b00000);
    step();
    chk_all("rel0_edge6", 5'b00000, 5'b00000, 5'b00001);
    step();
    chk_all("rel0_edge7", 5'b00000, 5'b00000, 5'b00000);
    repeat (3) step();

    // Bounce on btn[2]: the values are 1,0,1,1,0,1,1,1,1,1, bit i driven before edge i+1.
    // The final 0->1 is driven before edge 6, so the press is expected after edge 11.
    bounce_pat = 10'b1111101101;
    for (int i = 0; i < 10; i++) begin
      btn[2] = bounce_pat[i];
      step();
      chk_all("bounce_wait", 5'b00000, 5'b00000, 5'b00000);
    end
    step();
    chk_all("bounce_edge11", 5'b00100, 5'b00100, 5'b00000);
    step();
    chk_all("bounce_edge12", 5'b00100, 5'b00000, 5'b00000);
    btn[2] = 1'b0;
    repeat (6) step();
    chk_all("bounce_rel", 5'b00000, 5'b00000, 5'b00100);
    repeat (3) step();

    // A 3-cycle glitch on btn[4] must never be accepted.
    btn[4] = 1'b1;
    repeat (3) step();
    btn[4] = 1'b0;
    chk_all("glitch_0", 5'b00000, 5'b00000, 5'b00000);
    for (int i = 0; i < 10; i++) begin
      step();
      chk_all("glitch", 5'b00000, 5'b00000, 5'b00000);
    end

    // Assert reset mid-count on btn[1] after edge 4. The count restarts after rst_n is released.
    btn[1] = 1'b1;
    repeat (4) step();
    chk_all("midcnt_edge4", 5'b00000, 5'b00000, 5'b00000);
    #2 rst_n = 1'b0;
    #1;
    chk_all("midcnt_rst", 5'b00000, 5'b00000, 5'b00000);
    repeat (3) step();
    chk_all("midcnt_rsthold", 5'b00000, 5'b00000, 5'b00000);
    rst_n = 1'b1;
    repeat (5) step();
    chk_all("midcnt_edge5", 5'b00000, 5'b00000, 5'b00000);
    step();
    chk_all("midcnt_edge6", 5'b00010, 5'b00010, 5'b00000);

    // Assert reset asynchronously while btn_db[1] is set. The outputs must clear before the next edge.
    #3 rst_n = 1'b0;
    #1;
    chk_all("async_rst", 5'b00000, 5'b00000, 5'b00000);
    btn = 5'b00000;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (6) step();
    chk_all("post_rst_idle", 5'b00000, 5'b00000, 5'b00000);

    // Concurrent press on btn[3] and btn[0].
    btn = 5'b01001;
    repeat (5) step();
    chk_all("conc_edge5", 5'b00000, 5'b00000, 5'b00000);
    step();
    chk_all("conc_edge6", 5'b01001, 5'b01001, 5'b00000);
    step();
    chk_all("conc_edge7", 5'b01001, 5'b00000, 5'b00000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
